// File: rtl/rpn_eval_core.sv
// Postfix (RPN) evaluator: operands and operator characters arrive on two
// strobe/ack channels and are evaluated on an internal LIFO.
module rpn_eval_core #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        INPUT_SIGN,
    input  logic              SIGN_STB,
    output logic              SIGN_ACK,
    input  logic [IN_W-1:0]   INPUT_NUMBER,
    input  logic              NUMBER_STB,
    output logic              NUMBER_ACK,
    output logic              BUSY,
    output logic              READY,
    output logic [DATA_W-1:0] OUT,
    output logic              ERROR,
    output logic [1:0]        ERR_CODE,
    output logic [CNT_W-1:0]  LEVEL
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_EXEC,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   level_q, level_d;
    logic               sign_ack_q, sign_ack_d;
    logic               num_ack_q, num_ack_d;
    logic               ready_q, ready_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [1:0]         err_q, err_d;
    logic [IN_W-1:0]    opnd_q, opnd_d;
    logic [7:0]         op_q, op_d;

    logic [DATA_W-1:0]  stack_q [DEPTH];
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_data;

    logic [CNT_W-1:0]   lvl_m1, lvl_m2;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic [DATA_W-1:0]  op_a, op_b, alu;
    logic               is_arith, is_eq;

    assign lvl_m1 = level_q - CNT_W'(1);
    assign lvl_m2 = level_q - CNT_W'(2);
    assign idx_b  = lvl_m1[IDX_W-1:0];
    assign idx_a  = lvl_m2[IDX_W-1:0];
    assign op_b   = stack_q[idx_b];
    assign op_a   = stack_q[idx_a];

    assign is_arith = (op_q == CH_ADD) || (op_q == CH_SUB) || (op_q == CH_MUL);
    assign is_eq    = (op_q == CH_EQ);

    always_comb begin
        alu = op_a + op_b;
        if (op_q == CH_SUB) alu = op_a - op_b;
        if (op_q == CH_MUL) alu = op_a * op_b;
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        sign_ack_d = 1'b0;
        num_ack_d  = 1'b0;
        ready_d    = ready_q;
        out_d      = out_q;
        err_d      = err_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        wr_en      = 1'b0;
        wr_idx     = level_q[IDX_W-1:0];
        wr_data    = DATA_W'(opnd_q);
        case (state_q)
            S_IDLE: begin
                if (SIGN_STB) begin
                    sign_ack_d = 1'b1;
                    op_d       = INPUT_SIGN;
                    ready_d    = 1'b0;
                    out_d      = '0;
                    state_d    = S_EXEC;
                end else if (NUMBER_STB) begin
                    num_ack_d = 1'b1;
                    opnd_d    = INPUT_NUMBER;
                    ready_d   = 1'b0;
                    out_d     = '0;
                    state_d   = S_PUSH;
                end
            end
            S_PUSH: begin
                if (level_q == CNT_W'(DEPTH)) begin
                    err_d   = 2'd2;
                    state_d = S_FAULT;
                end else begin
                    wr_en   = 1'b1;
                    level_d = level_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_arith: begin
                        if (level_q < CNT_W'(2)) begin
                            err_d   = 2'd1;
                            state_d = S_FAULT;
                        end else begin
                            wr_en   = 1'b1;
                            wr_idx  = idx_a;
                            wr_data = alu;
                            level_d = lvl_m1;
                            state_d = S_IDLE;
                        end
                    end
                    is_eq: begin
                        if (level_q == CNT_W'(1)) begin
                            out_d   = op_b;
                            ready_d = 1'b1;
                            level_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            err_d   = 2'd3;
                            state_d = S_FAULT;
                        end
                    end
                    default: begin
                        err_d   = 2'd3;
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_FAULT: begin
                // keep draining upstream: one ack per two cycles, data dropped
                if (!(sign_ack_q || num_ack_q)) begin
                    if (SIGN_STB) begin
                        sign_ack_d = 1'b1;
                    end else if (NUMBER_STB) begin
                        num_ack_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            sign_ack_q <= 1'b0;
            num_ack_q  <= 1'b0;
            ready_q    <= 1'b0;
            out_q      <= '0;
            err_q      <= 2'd0;
            opnd_q     <= '0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            sign_ack_q <= sign_ack_d;
            num_ack_q  <= num_ack_d;
            ready_q    <= ready_d;
            out_q      <= out_d;
            err_q      <= err_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

    assign SIGN_ACK   = sign_ack_q;
    assign NUMBER_ACK = num_ack_q;
    assign BUSY       = (state_q != S_IDLE);
    assign ERROR      = (state_q == S_FAULT);
    assign READY      = ready_q;
    assign OUT        = out_q;
    assign ERR_CODE   = err_q;
    assign LEVEL      = level_q;

endmodule
